// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: bus field layout, DM window and bridge FSM states.
package mem_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RW_W        = 5;
  localparam int unsigned MEM_CTRL_W  = 4;
  localparam int unsigned WB_CTRL_W   = 5;
  localparam int unsigned MEM_DATA_W  = RW_W + 2 * XLEN;
  localparam int unsigned DM_ADDR_W   = 10;
  localparam int unsigned DM_ADDR_LSB = 2;
  localparam int unsigned DM_WE_W     = 4;

  // Addresses (low half-word) below this go to data memory, the rest to the bridge.
  localparam logic [15:0] DM_LIMIT = 16'h3000;

  // Peripheral bridge handshake states.
  typedef enum logic [1:0] {
    PR_IDLE       = 2'd0,
    PR_WAIT       = 2'd1,
    PR_DONE       = 2'd2,
    PR_DONE_ABORT = 2'd3
  } pr_state_e;

  // MEM_CTRL layout, MSB first.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic is_byte;
    logic is_half;
  } mem_ctrl_t;

  // WB_CTRL layout, MSB first.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic is_dm_byte;
    logic is_dm_half;
    logic is_loads;
  } wb_ctrl_t;

  // MEM_DATA / WB_DATA layout, MSB first; ex_out is the effective address.
  typedef struct packed {
    logic [RW_W-1:0] rw;
    logic [XLEN-1:0] ex_out;
    logic [XLEN-1:0] rt_data;
  } mem_data_t;

  // True when the address falls in the data-memory window.
  function automatic logic addr_in_dm(input logic [15:0] addr_lo);
    return addr_lo < DM_LIMIT;
  endfunction

endpackage

// File: rtl/mem_stage_dm_wr_align.sv
// Store lane steering and alignment check for data-memory accesses.
module dm_wr_align
  import mem_pkg::*;
(
  input  logic [1:0]         addr_lo,
  input  logic               is_byte,
  input  logic               is_half,
  input  logic [XLEN-1:0]    rt,
  output logic [DM_WE_W-1:0] we,
  output logic [XLEN-1:0]    wd,
  output logic               misaligned
);

  // Select byte lanes and replicate store data across them.
  always_comb begin
    we         = '0;
    wd         = rt;
    misaligned = (is_half && addr_lo[0]) || (!is_byte && !is_half && (addr_lo != 2'b00));
    if (is_byte) begin
      we = DM_WE_W'(4'b0001 << addr_lo);
      wd = {4{rt[7:0]}};
    end else if (is_half) begin
      we = addr_lo[1] ? 4'b1100 : 4'b0011;
      wd = {2{rt[15:0]}};
    end else begin
      we = 4'b1111;
      wd = rt;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: DM stores/reads, peripheral bridge handshake, MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned PR_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [MEM_CTRL_W-1:0] MEM_CTRL,
  input  logic [WB_CTRL_W-1:0]  i_WB_CTRL,
  input  logic [MEM_DATA_W-1:0] MEM_DATA,
  output logic [DM_ADDR_W-1:0]  DM_addr,
  output logic [DM_WE_W-1:0]    DM_we,
  output logic [XLEN-1:0]       DM_wd,
  output logic [XLEN-1:0]       PrAddr,
  output logic [XLEN-1:0]       PrWD,
  output logic                  PrWE,
  output logic                  PrReq,
  input  logic                  PrReady,
  input  logic [XLEN-1:0]       PrRD_in,
  output logic                  o_stall,
  output logic [WB_CTRL_W-1:0]  WB_CTRL,
  output logic [MEM_DATA_W-1:0] WB_DATA,
  output logic [XLEN-1:0]       PrRD,
  output logic                  o_exc_align,
  output logic                  o_bus_err
);

  localparam int unsigned CNT_W = (PR_TIMEOUT < 1) ? 1 : $clog2(PR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PR_TIMEOUT);

  mem_ctrl_t ctrl;
  mem_data_t md;
  logic      access;
  logic      in_dm;
  logic      misaligned;

  logic [DM_WE_W-1:0] lane_we;
  logic [XLEN-1:0]    lane_wd;

  pr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pr_addr_q, pr_addr_d;
  logic [XLEN-1:0]  pr_wd_q, pr_wd_d;
  logic             pr_we_q, pr_we_d;
  logic [XLEN-1:0]  pr_rd_q, pr_rd_d;
  wb_ctrl_t         wb_ctrl_q, wb_ctrl_d;
  mem_data_t        wb_data_q, wb_data_d;
  logic             exc_align_q, exc_align_d;
  logic             bus_err_q, bus_err_d;

  logic               pr_req_c;
  logic               stall_c;
  logic [DM_WE_W-1:0] dm_we_c;

  // Decode of the instruction currently in MEM.
  assign ctrl   = mem_ctrl_t'(MEM_CTRL);
  assign md     = mem_data_t'(MEM_DATA);
  assign access = i_valid & (ctrl.mem_read | ctrl.mem_write);
  assign in_dm  = addr_in_dm(md.ex_out[15:0]);

  dm_wr_align u_dm_wr_align (
    .addr_lo    (md.ex_out[1:0]),
    .is_byte    (ctrl.is_byte),
    .is_half    (ctrl.is_half),
    .rt         (md.rt_data),
    .we         (lane_we),
    .wd         (lane_wd),
    .misaligned (misaligned)
  );

  // Bridge FSM next state, MEM/WB next values and combinational strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_addr_d   = pr_addr_q;
    pr_wd_d     = pr_wd_q;
    pr_we_d     = pr_we_q;
    pr_rd_d     = pr_rd_q;
    wb_ctrl_d   = '0;
    wb_data_d   = '0;
    exc_align_d = 1'b0;
    bus_err_d   = 1'b0;
    pr_req_c    = 1'b0;
    stall_c     = 1'b0;
    dm_we_c     = '0;

    unique case (state_q)
      PR_IDLE: begin
        if (i_valid) begin
          if (access && misaligned) begin
            exc_align_d = 1'b1;
          end else if (access && !in_dm) begin
            pr_req_c  = 1'b1;
            stall_c   = 1'b1;
            pr_addr_d = md.ex_out;
            pr_wd_d   = md.rt_data;
            pr_we_d   = ctrl.mem_write;
            cnt_d     = '0;
            state_d   = PR_WAIT;
          end else begin
            wb_ctrl_d = wb_ctrl_t'(i_WB_CTRL);
            wb_data_d = md;
            if (access && ctrl.mem_write) begin
              dm_we_c = lane_we;
            end
          end
        end
      end

      PR_WAIT: begin
        pr_req_c = 1'b1;
        stall_c  = 1'b1;
        if (PrReady) begin
          if (!pr_we_q) begin
            pr_rd_d = PrRD_in;
          end
          state_d = PR_DONE;
        end else if (cnt_q == CNT_MAX) begin
          bus_err_d = 1'b1;
          state_d   = PR_DONE_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // EX/MEM was frozen during the access, so MEM_DATA still holds it here.
      PR_DONE: begin
        wb_ctrl_d = wb_ctrl_t'(i_WB_CTRL);
        wb_data_d = md;
        state_d   = PR_IDLE;
      end

      PR_DONE_ABORT: begin
        state_d = PR_IDLE;
      end

      default: begin
        state_d = PR_IDLE;
      end
    endcase

    if (rst) begin
      pr_req_c = 1'b0;
      stall_c  = 1'b0;
      dm_we_c  = '0;
    end
  end

  // State and MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PR_IDLE;
      cnt_q       <= '0;
      pr_addr_q   <= '0;
      pr_wd_q     <= '0;
      pr_we_q     <= 1'b0;
      pr_rd_q     <= '0;
      wb_ctrl_q   <= '0;
      wb_data_q   <= '0;
      exc_align_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_addr_q   <= pr_addr_d;
      pr_wd_q     <= pr_wd_d;
      pr_we_q     <= pr_we_d;
      pr_rd_q     <= pr_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_data_q   <= wb_data_d;
      exc_align_q <= exc_align_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Bridge address/data come straight from MEM in IDLE, then from the latched copy.
  assign PrAddr = (state_q == PR_IDLE) ? md.ex_out  : pr_addr_q;
  assign PrWD   = (state_q == PR_IDLE) ? md.rt_data : pr_wd_q;
  assign PrWE   = pr_req_c & ((state_q == PR_IDLE) ? ctrl.mem_write : pr_we_q);
  assign PrReq  = pr_req_c;

  assign DM_addr = md.ex_out[DM_ADDR_LSB +: DM_ADDR_W];
  assign DM_we   = dm_we_c;
  assign DM_wd   = lane_wd;
  assign o_stall = stall_c;

  assign WB_CTRL     = wb_ctrl_q;
  assign WB_DATA     = wb_data_q;
  assign PrRD        = pr_rd_q;
  assign o_exc_align = exc_align_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (bridge timeout shortened to 4).
module tb_mem_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  ctrl;
    logic [4:0]  wb;
    logic [4:0]  rw;
    logic [31:0] ex;
    logic [31:0] rt;
  } ins_t;

  localparam logic [3:0] C_LW  = 4'b1000;
  localparam logic [3:0] C_SW  = 4'b0100;
  localparam logic [3:0] C_SB  = 4'b0110;
  localparam logic [3:0] C_SH  = 4'b0101;
  localparam logic [3:0] C_ALU = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [3:0]  MEM_CTRL;
  logic [4:0]  i_WB_CTRL;
  logic [68:0] MEM_DATA;
  logic [9:0]  DM_addr;
  logic [3:0]  DM_we;
  logic [31:0] DM_wd;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic        PrReq;
  logic        PrReady;
  logic [31:0] PrRD_in;
  logic        o_stall;
  logic [4:0]  WB_CTRL;
  logic [68:0] WB_DATA;
  logic [31:0] PrRD;
  logic        o_exc_align;
  logic        o_bus_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage #(.PR_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .MEM_CTRL(MEM_CTRL), .i_WB_CTRL(i_WB_CTRL),
    .MEM_DATA(MEM_DATA), .DM_addr(DM_addr), .DM_we(DM_we), .DM_wd(DM_wd),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE), .PrReq(PrReq), .PrReady(PrReady),
    .PrRD_in(PrRD_in), .o_stall(o_stall), .WB_CTRL(WB_CTRL), .WB_DATA(WB_DATA),
    .PrRD(PrRD), .o_exc_align(o_exc_align), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got running want finished");
    $fatal(1, "bench timeout");
  end

  function automatic ins_t mk(input logic v, input logic [3:0] c, input logic [4:0] wb,
                              input logic [4:0] rw, input logic [31:0] ex, input logic [31:0] rt);
    ins_t i;
    i.v = v; i.ctrl = c; i.wb = wb; i.rw = rw; i.ex = ex; i.rt = rt;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    i_valid   = i.v;
    MEM_CTRL  = i.ctrl;
    i_WB_CTRL = i.wb;
    MEM_DATA  = {i.rw, i.ex, i.rt};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; PrReady = 1'b0; PrRD_in = 32'h0;
    drive(mk(1'b1, C_SW, 5'h1F, 5'd1, 32'h0, 32'hFFFF_FFFF));
    tick; #1;
    n_cmp++; if (DM_we !== 4'b0000) begin n_fail++; $display("FAIL rst_dm_we: got %b want 0000", DM_we); end
    n_cmp++; if ({PrReq, o_stall} !== 2'b00) begin n_fail++; $display("FAIL rst_req_stall: got %b want 00", {PrReq, o_stall}); end
    n_cmp++; if (WB_CTRL !== 5'h0) begin n_fail++; $display("FAIL rst_wb_ctrl: got %h want 00", WB_CTRL); end
    n_cmp++; if (WB_DATA !== 69'h0) begin n_fail++; $display("FAIL rst_wb_data: got %h want 0", WB_DATA); end
    n_cmp++; if (PrRD !== 32'h0) begin n_fail++; $display("FAIL rst_prrd: got %h want 0", PrRD); end
    n_cmp++; if ({o_exc_align, o_bus_err} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {o_exc_align, o_bus_err}); end
    tick;
    drive(mk(1'b1, C_LW, 5'h19, 5'd1, 32'h3000, 32'h0));
    #1;
    n_cmp++; if ({PrReq, o_stall} !== 2'b00) begin n_fail++; $display("FAIL rst_periph_req: got %b want 00", {PrReq, o_stall}); end
    n_cmp++; if (WB_CTRL !== 5'h0) begin n_fail++; $display("FAIL rst_hold_wb: got %h want 00", WB_CTRL); end
    tick;
    rst = 1'b0;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0));
    tick;
  endtask

  task automatic test_dm_access;
    ins_t        tab [4];
    logic [3:0]  e_we [4];
    logic [31:0] e_wd [4];
    logic [9:0]  e_ad [4];
    tab[0] = mk(1'b1, C_SB, 5'h05, 5'd2, 32'h0000_0102, 32'h0000_00AB);
    e_we[0] = 4'b0100; e_wd[0] = 32'hABAB_ABAB; e_ad[0] = 10'h040;
    tab[1] = mk(1'b1, C_SH, 5'h06, 5'd3, 32'h0000_0106, 32'h1234_BEEF);
    e_we[1] = 4'b1100; e_wd[1] = 32'hBEEF_BEEF; e_ad[1] = 10'h041;
    tab[2] = mk(1'b1, C_SW, 5'h07, 5'd4, 32'h0000_0010, 32'hCAFE_0123);
    e_we[2] = 4'b1111; e_wd[2] = 32'hCAFE_0123; e_ad[2] = 10'h004;
    tab[3] = mk(1'b1, C_LW, 5'h19, 5'd5, 32'h0000_2FFC, 32'h1111_2222);
    e_we[3] = 4'b0000; e_wd[3] = 32'h1111_2222; e_ad[3] = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(tab[i]);
      else drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0));
      #1;
      if (i < 4) begin
        n_cmp++; if (DM_we !== e_we[i]) begin n_fail++; $display("FAIL dm_we[%0d]: got %b want %b", i, DM_we, e_we[i]); end
        n_cmp++; if (DM_wd !== e_wd[i]) begin n_fail++; $display("FAIL dm_wd[%0d]: got %h want %h", i, DM_wd, e_wd[i]); end
        n_cmp++; if (DM_addr !== e_ad[i]) begin n_fail++; $display("FAIL dm_addr[%0d]: got %h want %h", i, DM_addr, e_ad[i]); end
        n_cmp++; if ({o_stall, PrReq} !== 2'b00) begin n_fail++; $display("FAIL dm_nostall[%0d]: got %b want 00", i, {o_stall, PrReq}); end
      end
      if (i > 0) begin
        n_cmp++; if (WB_CTRL !== tab[i-1].wb) begin n_fail++; $display("FAIL dm_wb_ctrl[%0d]: got %h want %h", i-1, WB_CTRL, tab[i-1].wb); end
        n_cmp++; if (WB_DATA !== {tab[i-1].rw, tab[i-1].ex, tab[i-1].rt}) begin n_fail++; $display("FAIL dm_wb_data[%0d]: got %h want %h", i-1, WB_DATA, {tab[i-1].rw, tab[i-1].ex, tab[i-1].rt}); end
      end
      tick;
    end
    #1;
    n_cmp++; if (WB_CTRL !== 5'h0) begin n_fail++; $display("FAIL dm_bubble_wb: got %h want 00", WB_CTRL); end
  endtask

  task automatic test_periph_load;
    ins_t lw;
    int   n_stall;
    lw = mk(1'b1, C_LW, 5'h19, 5'd7, 32'h0000_3004, 32'h0);
    n_stall = 0;
    drive(lw); #1;
    if (o_stall) n_stall++;
    n_cmp++; if ({PrReq, PrWE} !== 2'b10) begin n_fail++; $display("FAIL pld_idle_req: got %b want 10", {PrReq, PrWE}); end
    n_cmp++; if (PrAddr !== 32'h3004) begin n_fail++; $display("FAIL pld_addr: got %h want 00003004", PrAddr); end
    n_cmp++; if (DM_we !== 4'b0000) begin n_fail++; $display("FAIL pld_dm_we: got %b want 0000", DM_we); end
    tick;
    PrReady = 1'b1; PrRD_in = 32'h1234_5678; #1;
    if (o_stall) n_stall++;
    n_cmp++; if ({PrReq, PrAddr} !== {1'b1, 32'h3004}) begin n_fail++; $display("FAIL pld_wait: got req=%b addr=%h want req=1 addr=00003004", PrReq, PrAddr); end
    n_cmp++; if (WB_CTRL !== 5'h0) begin n_fail++; $display("FAIL pld_bubble1: got %h want 00", WB_CTRL); end
    tick;
    PrReady = 1'b0; PrRD_in = 32'hDEAD_BEEF; #1;
    if (o_stall) n_stall++;
    n_cmp++; if (PrReq !== 1'b0) begin n_fail++; $display("FAIL pld_done_req: got %b want 0", PrReq); end
    n_cmp++; if (WB_CTRL !== 5'h0) begin n_fail++; $display("FAIL pld_bubble2: got %h want 00", WB_CTRL); end
    n_cmp++; if (n_stall !== 2) begin n_fail++; $display("FAIL pld_stall_cnt: got %0d want 2", n_stall); end
    tick;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0)); #1;
    n_cmp++; if (WB_CTRL !== 5'h19) begin n_fail++; $display("FAIL pld_wb_ctrl: got %h want 19", WB_CTRL); end
    n_cmp++; if (WB_DATA !== {5'd7, 32'h3004, 32'h0}) begin n_fail++; $display("FAIL pld_wb_data: got %h want %h", WB_DATA, {5'd7, 32'h3004, 32'h0}); end
    n_cmp++; if (PrRD !== 32'h1234_5678) begin n_fail++; $display("FAIL pld_prrd: got %h want 12345678", PrRD); end
    tick;
  endtask

  task automatic test_timeout;
    ins_t sw;
    int   n_stall, n_req, n_err, err_at;
    logic wb_dirty, pr_ok;
    sw = mk(1'b1, C_SW, 5'h02, 5'd0, 32'h0000_3008, 32'hCAFE_F00D);
    n_stall = 0; n_req = 0; n_err = 0; err_at = -1; wb_dirty = 1'b0; pr_ok = 1'b1;
    PrReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c <= 6) drive(sw);
      else drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0));
      #1;
      if (o_stall) n_stall++;
      if (PrReq) n_req++;
      if (o_bus_err) begin n_err++; err_at = c; end
      if (WB_CTRL !== 5'h0 || WB_DATA !== 69'h0) wb_dirty = 1'b1;
      if (PrReq && (PrWE !== 1'b1 || PrAddr !== 32'h3008 || PrWD !== 32'hCAFE_F00D)) pr_ok = 1'b0;
      tick;
    end
    n_cmp++; if (n_stall !== 6) begin n_fail++; $display("FAIL to_stall_cnt: got %0d want 6", n_stall); end
    n_cmp++; if (n_req !== 6) begin n_fail++; $display("FAIL to_req_cnt: got %0d want 6", n_req); end
    n_cmp++; if (n_err !== 1 || err_at !== 6) begin n_fail++; $display("FAIL to_bus_err: got %0d pulses at %0d want 1 at 6", n_err, err_at); end
    n_cmp++; if (wb_dirty !== 1'b0) begin n_fail++; $display("FAIL to_wb_bubble: got dirty=%b want 0", wb_dirty); end
    n_cmp++; if (pr_ok !== 1'b1) begin n_fail++; $display("FAIL to_bridge_bus: got ok=%b want 1", pr_ok); end
    drive(mk(1'b1, C_SB, 5'h00, 5'd0, 32'h0, 32'h0000_005A)); #1;
    n_cmp++; if ({o_stall, DM_we} !== {1'b0, 4'b0001}) begin n_fail++; $display("FAIL to_back_idle: got stall=%b we=%b want stall=0 we=0001", o_stall, DM_we); end
    tick;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0));
    tick;
  endtask

  task automatic test_misaligned;
    drive(mk(1'b1, C_SH, 5'h1F, 5'd6, 32'h0000_0001, 32'h0000_1234)); #1;
    n_cmp++; if ({DM_we, PrReq, o_stall} !== 6'b0) begin n_fail++; $display("FAIL mis_sh_quiet: got we=%b req=%b stall=%b want 0", DM_we, PrReq, o_stall); end
    n_cmp++; if (o_exc_align !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", o_exc_align); end
    tick;
    drive(mk(1'b1, C_LW, 5'h19, 5'd6, 32'h0000_3002, 32'h0)); #1;
    n_cmp++; if (o_exc_align !== 1'b1) begin n_fail++; $display("FAIL mis_sh_pulse: got %b want 1", o_exc_align); end
    n_cmp++; if ({WB_CTRL, WB_DATA} !== 74'h0) begin n_fail++; $display("FAIL mis_sh_bubble: got %h/%h want 0", WB_CTRL, WB_DATA); end
    n_cmp++; if ({PrReq, o_stall} !== 2'b00) begin n_fail++; $display("FAIL mis_lw_noreq: got %b want 00", {PrReq, o_stall}); end
    tick;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0)); #1;
    n_cmp++; if ({o_exc_align, WB_CTRL} !== {1'b1, 5'h0}) begin n_fail++; $display("FAIL mis_lw_pulse: got exc=%b wb=%h want exc=1 wb=00", o_exc_align, WB_CTRL); end
    tick; #1;
    n_cmp++; if (o_exc_align !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", o_exc_align); end
    tick;
  endtask

  task automatic test_rst_in_wait;
    ins_t lw;
    lw = mk(1'b1, C_LW, 5'h19, 5'd8, 32'h0000_3010, 32'h0);
    PrReady = 1'b0;
    drive(lw); #1;
    n_cmp++; if (PrReq !== 1'b1) begin n_fail++; $display("FAIL rw_idle_req: got %b want 1", PrReq); end
    tick; #1;
    n_cmp++; if (PrReq !== 1'b1) begin n_fail++; $display("FAIL rw_wait1_req: got %b want 1", PrReq); end
    tick;
    rst = 1'b1; #1;
    n_cmp++; if ({PrReq, o_stall} !== 2'b00) begin n_fail++; $display("FAIL rw_rst_drop: got %b want 00", {PrReq, o_stall}); end
    tick;
    rst = 1'b0; #1;
    n_cmp++; if ({WB_CTRL, WB_DATA, PrRD, o_exc_align, o_bus_err} !== 108'h0) begin n_fail++; $display("FAIL rw_regs_zero: got wb=%h data=%h prrd=%h exc=%b err=%b want 0", WB_CTRL, WB_DATA, PrRD, o_exc_align, o_bus_err); end
    n_cmp++; if ({PrReq, o_stall} !== 2'b11) begin n_fail++; $display("FAIL rw_fresh_req: got %b want 11", {PrReq, o_stall}); end
    tick;
    PrReady = 1'b1; PrRD_in = 32'hA5A5_0001; #1;
    n_cmp++; if (PrReq !== 1'b1) begin n_fail++; $display("FAIL rw_fresh_wait: got %b want 1", PrReq); end
    tick;
    PrReady = 1'b0; PrRD_in = 32'h0; #1;
    n_cmp++; if ({PrReq, o_stall, PrRD} !== {2'b00, 32'hA5A5_0001}) begin n_fail++; $display("FAIL rw_fresh_done: got req=%b stall=%b prrd=%h want 0 0 a5a50001", PrReq, o_stall, PrRD); end
    tick;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0)); #1;
    n_cmp++; if (WB_CTRL !== 5'h19) begin n_fail++; $display("FAIL rw_fresh_wb: got %h want 19", WB_CTRL); end
    tick;
  endtask

  task automatic test_back_to_back;
    ins_t       prog [3];
    logic [4:0] exp_wb [6];
    int         idx, n_stall;
    logic       stalled;
    prog[0] = mk(1'b1, C_LW, 5'h19, 5'd3, 32'h0000_3000, 32'h0);
    prog[1] = mk(1'b1, C_ALU, 5'h10, 5'd9, 32'h0000_0055, 32'h0000_0001);
    prog[2] = mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0);
    exp_wb = '{5'h00, 5'h00, 5'h00, 5'h19, 5'h10, 5'h00};
    idx = 0; n_stall = 0;
    for (int c = 0; c < 6; c++) begin
      PrReady = (c == 1);
      PrRD_in = (c == 1) ? 32'h0BAD_F00D : 32'hFFFF_FFFF;
      drive(prog[idx]); #1;
      n_cmp++; if (WB_CTRL !== exp_wb[c]) begin n_fail++; $display("FAIL b2b_wb_ctrl[%0d]: got %h want %h", c, WB_CTRL, exp_wb[c]); end
      if (c == 3) begin
        n_cmp++; if (PrRD !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_prrd: got %h want 0badf00d", PrRD); end
        n_cmp++; if (WB_DATA !== {5'd3, 32'h3000, 32'h0}) begin n_fail++; $display("FAIL b2b_lw_data: got %h want %h", WB_DATA, {5'd3, 32'h3000, 32'h0}); end
      end
      if (c == 4) begin
        n_cmp++; if (WB_DATA !== {5'd9, 32'h55, 32'h1}) begin n_fail++; $display("FAIL b2b_add_data: got %h want %h", WB_DATA, {5'd9, 32'h55, 32'h1}); end
      end
      stalled = o_stall;
      if (stalled) n_stall++;
      tick;
      if (!stalled && idx < 2) idx++;
    end
    PrReady = 1'b0;
    n_cmp++; if (n_stall !== 2) begin n_fail++; $display("FAIL b2b_stall_cnt: got %0d want 2", n_stall); end
  endtask

  initial begin
    rst = 1'b1; PrReady = 1'b0; PrRD_in = 32'h0;
    drive(mk(1'b0, C_ALU, 5'h0, 5'd0, 32'h0, 32'h0));
    test_reset();
    test_dm_access();
    test_periph_load();
    test_timeout();
    test_misaligned();
    test_rst_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly upstream of WB. Each cycle it takes the instruction leaving EX, performs data-memory stores and issues data-memory reads (DM is synchronous, read data arrives as Dout in WB), and runs a multi-cycle request/ready handshake to the peripheral bridge for addresses at or above 0x3000. It owns the MEM/WB pipeline register that drives WB_CTRL, WB_DATA and the latched peripheral read data PrRD consumed by WB.

## Interface
- PR_TIMEOUT, 255: max cycles spent in WAIT before the bridge access is aborted.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction in MEM is real (not a bubble).
- MEM_CTRL  in  4  {memRead, memWrite, isByte, isHalf}.
- i_WB_CTRL  in  5  {regWrite, memToReg, isDMByte, isDMHalf, isLOADS}, forwarded to WB.
- MEM_DATA  in  69  {rw[4:0], EXout[31:0], rtData[31:0]}; EXout is the effective address.
- DM_addr  out  10  word address, EXout[11:2].
- DM_we  out  4  byte-lane write enables.
- DM_wd  out  32  lane-replicated store data.
- PrAddr  out  32  bridge address (EXout, held during access).
- PrWD  out  32  bridge write data (rtData, held).
- PrWE  out  1  bridge write strobe, valid with PrReq.
- PrReq  out  1  bridge request.
- PrReady  in  1  bridge completion.
- PrRD_in  in  32  bridge read data, valid when PrReady=1.
- o_stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- WB_CTRL  out  5  registered.
- WB_DATA  out  69  registered.
- PrRD  out  32  registered bridge read data.
- o_exc_align  out  1  registered one-cycle misalignment pulse.
- o_bus_err  out  1  registered one-cycle bridge-timeout pulse.

## Operation
- Decode: inDM = EXout[15:0] < 16'h3000; access = i_valid & (memRead | memWrite).
- Alignment: misaligned = (isHalf & EXout[0]) | (!isByte & !isHalf & EXout[1:0]!=0). A misaligned access issues no DM or bridge activity, writes a bubble to MEM/WB, and pulses o_exc_align.
- DM store, IDLE only: byte → DM_we = 1<<EXout[1:0], DM_wd = {4{rt[7:0]}}; half → DM_we = EXout[1]?4'b1100:4'b0011, DM_wd = {2{rt[15:0]}}; word → 4'b1111, DM_wd = rt. DM_we = 0 otherwise. DM_addr is always driven.
- Peripheral FSM states IDLE, WAIT, DONE:
  - IDLE: an aligned peripheral access drives PrReq=1 and o_stall=1, latches addr, data and PrWE, loads the timeout counter to 0, and moves to WAIT. DM and non-memory instructions advance without stalling.
  - WAIT: PrReq=1, o_stall=1, counter increments. When PrReady=1, PrRD <= PrRD_in (loads only) and the FSM goes to DONE. When the counter reaches PR_TIMEOUT with no PrReady, it pulses o_bus_err, writes a bubble, and goes to DONE_ABORT, handled as DONE with a bubble.
  - DONE: PrReq=0, o_stall=0; the instruction advances into MEM/WB; next state IDLE; no re-request.
- MEM/WB register: on advance, WB_CTRL <= i_WB_CTRL and WB_DATA <= MEM_DATA. Otherwise (stall, bubble, misaligned, abort) WB_CTRL <= 0 and WB_DATA <= 0. PrRD holds until the next latch.

## Timing
- Reset: state IDLE, WB_CTRL=0, WB_DATA=0, PrRD=0, counter=0, o_exc_align=0, o_bus_err=0. Combinational outputs PrReq, DM_we and o_stall are 0 while rst=1.
- DM or ALU instruction: zero stall; it appears in WB the next cycle; DM read data is valid then.
- Peripheral access: minimum 2 stall cycles (IDLE and WAIT with immediate PrReady); the instruction reaches WB 3 cycles after entering MEM. PrReady is sampled only in WAIT.
- Timeout: PR_TIMEOUT+1 WAIT cycles, then DONE.
- rst during WAIT: aborts immediately; PrReq drops the same cycle.
- i_valid=0: always a bubble and never a request.

## Structure
- mem_pkg holds the state enum, DM_LIMIT=16'h3000, and the field widths/offsets of MEM_CTRL, WB_CTRL and MEM_DATA (shared with WB and EX).
- Sub-module dm_wr_align (combinational): {EXout[1:0], isByte, isHalf, rt} → {DM_we, DM_wd, misaligned}.

## Test plan
- sb at EXout=0x0000_0102, rt=0x0000_00AB → DM_we=4'b0100, DM_wd=0xABABABAB, DM_addr=0x040, no stall, WB_CTRL follows next cycle.
- lw at 0x0000_3004, PrReady asserted in the first WAIT cycle with PrRD_in=0x1234_5678 → o_stall high 2 cycles, PrReq high 2 cycles, PrRD=0x12345678 in the cycle WB_CTRL=i_WB_CTRL; bubbles before.
- sw to 0x3008 with PR_TIMEOUT=4 and PrReady never asserted → 6 stall cycles, o_bus_err one pulse, WB_CTRL stays 0, FSM back to IDLE.
- sh at 0x0000_0001 → DM_we=0, no PrReq, o_exc_align one pulse next cycle, WB_CTRL=0.
- rst asserted in the 2nd WAIT cycle → PrReq=0 the same cycle, all registered outputs 0, next peripheral access issues a fresh request.
- Back-to-back lw 0x3000 then add → add is held in EX until DONE, reaches WB exactly one cycle after the lw.
